// File: rtl/unifiedmem_arbiter_if.sv
// Requester-side and memory-side buses of the 7-bank unified-memory arbiter.
// The arbiter binds the slave modport; masters and the memory model use the master modport.
interface unifiedmem_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int NBANK = 7;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*WIDTH-1:0]  req_addr;
    logic [NREQ*WIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [NREQ*WIDTH-1:0]  rdata;
    logic [NREQ-1:0]        err;
    logic [NBANK-1:0]       mem_we;
    logic [NBANK*WIDTH-1:0] mem_a;
    logic [NBANK*WIDTH-1:0] mem_wd;
    logic [NBANK*WIDTH-1:0] mem_rd;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rd,
        output gnt, rvalid, rdata, err, mem_we, mem_a, mem_wd
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rd,
        input  gnt, rvalid, rdata, err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/unifiedmem_arbiter.sv
// Per-bank round-robin arbiter sharing a 7-bank single-port memory between NREQ masters.
// Latency: gnt combinational, rvalid/rdata/err registered 1 cycle after req&gnt.
// Backpressure: losers see gnt=0 and hold req; UNIFIEDMEM_ARB_PRIO0_EN gives requester 0 fixed priority.
module unifiedmem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int RAMSIZE = 512,
    parameter int NREQ    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    unifiedmem_arbiter_if.slave  bus
);
    localparam int         IDXW     = $clog2(RAMSIZE);
    localparam int         NBANK    = 7;
    localparam int         PW       = $clog2(NREQ);
    localparam logic [2:0] BANK_ERR = 3'd7;

    logic [2:0]             bank_f  [NREQ];
    logic [IDXW-1:0]        idx_f   [NREQ];
    logic [PW-1:0]          rr_ptr  [NBANK];
    logic [PW-1:0]          win_idx [NBANK];
    logic [NBANK-1:0]       win_vld;
    logic [NBANK-1:0]       rr_upd;

    logic [NREQ-1:0]        gnt_c;
    logic [NBANK-1:0]       mem_we_c;
    logic [NBANK*WIDTH-1:0] mem_a_c;
    logic [NBANK*WIDTH-1:0] mem_wd_c;

    logic [NREQ-1:0]        err_n;
    logic [NREQ*WIDTH-1:0]  rdata_n;
    logic [NREQ-1:0]        rvalid_q;
    logic [NREQ-1:0]        err_q;
    logic [NREQ*WIDTH-1:0]  rdata_q;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bank_f[i] = bus.req_addr[i*WIDTH+IDXW +: 3];
            idx_f[i]  = bus.req_addr[i*WIDTH +: IDXW];
        end
    end

    // Scan backwards so the last hit is the first candidate after rr_ptr.
    always_comb begin
        int cand;
        cand    = 0;
        win_vld = '0;
        rr_upd  = '0;
        for (int b = 0; b < NBANK; b++) begin
            win_idx[b] = '0;
            for (int k = NREQ; k >= 1; k--) begin
                cand = (int'(rr_ptr[b]) + k) % NREQ;
                if (bus.req[cand] && (bank_f[cand] == 3'(b))) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = PW'(cand);
                end
            end
`ifdef UNIFIEDMEM_ARB_PRIO0_EN
            if (bus.req[0] && (bank_f[0] == 3'(b))) begin
                win_vld[b] = 1'b1;
                win_idx[b] = '0;
            end
            rr_upd[b] = win_vld[b] && (win_idx[b] != '0);
`else
            rr_upd[b] = win_vld[b];
`endif
        end
    end

    always_comb begin
        gnt_c    = '0;
        mem_we_c = '0;
        mem_a_c  = '0;
        mem_wd_c = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (win_vld[b]) begin
                gnt_c[win_idx[b]]          = 1'b1;
                mem_we_c[b]                = bus.req_we[win_idx[b]];
                mem_a_c[b*WIDTH +: WIDTH]  = WIDTH'(idx_f[win_idx[b]]);
                mem_wd_c[b*WIDTH +: WIDTH] = bus.req_wdata[int'(win_idx[b])*WIDTH +: WIDTH];
            end
        end
        // Illegal bank is accepted at once and answered with err; it never touches memory.
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && (bank_f[i] == BANK_ERR)) begin
                gnt_c[i] = 1'b1;
            end
        end
        if (reset) begin
            gnt_c    = '0;
            mem_we_c = '0;
        end
    end

    // Read data is the pre-write memory value seen in the grant cycle.
    always_comb begin
        err_n   = '0;
        rdata_n = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                if (bank_f[i] == BANK_ERR) begin
                    err_n[i] = 1'b1;
                end else if (!bus.req_we[i]) begin
                    rdata_n[i*WIDTH +: WIDTH] = bus.mem_rd[int'(bank_f[i])*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NBANK; b++) begin
                rr_ptr[b] <= PW'(NREQ-1);
            end
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (rr_upd[b]) begin
                    rr_ptr[b] <= win_idx[b];
                end
            end
            rvalid_q <= gnt_c;
            err_q    <= err_n;
            rdata_q  <= rdata_n;
        end
    end

    assign bus.gnt    = gnt_c;
    assign bus.mem_we = mem_we_c;
    assign bus.mem_a  = mem_a_c;
    assign bus.mem_wd = mem_wd_c;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_unifiedmem_arbiter.sv
// Bench for unifiedmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-free behavioural model with its own golden memory copy.
module tb_unifiedmem_arbiter;
    localparam int W    = 32;
    localparam int RS   = 512;
    localparam int N    = 4;
    localparam int IDXW = 9;
    localparam int NB   = 7;
`ifdef UNIFIEDMEM_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic init_mem;
    always #5 clk = ~clk;

    unifiedmem_arbiter_if #(.WIDTH(W), .NREQ(N)) u_if ();

    unifiedmem_arbiter #(.WIDTH(W), .RAMSIZE(RS), .NREQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    // Memory environment: combinational read, write on posedge.
    logic [W-1:0] mem [NB][RS];

    function automatic logic [W-1:0] pat(int b, int k);
        if (b == 2 && k == 5) return 32'h0000_00A5;
        return 32'hC000_0000 | W'(b << 16) | W'(k);
    endfunction

    always_comb begin
        for (int b = 0; b < NB; b++)
            u_if.mem_rd[b*W +: W] = mem[b][u_if.mem_a[b*W +: IDXW]];
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < RS; k++)
                    mem[b][k] <= pat(b, k);
        end else begin
            for (int b = 0; b < NB; b++)
                if (u_if.mem_we[b]) mem[b][u_if.mem_a[b*W +: IDXW]] <= u_if.mem_wd[b*W +: W];
        end
    end

    // Requester stimulus state
    logic         rq_v  [N];
    logic         rq_we [N];
    logic [W-1:0] rq_addr [N];
    logic [W-1:0] rq_wd [N];

    // Behavioural model state
    int              m_ptr [NB];
    logic [N-1:0]    m_rv, m_err;
    logic [N*W-1:0]  m_rd;
    logic [W-1:0]    gold [NB][RS];
    logic [N-1:0]    e_gnt;
    logic [NB-1:0]   e_we;
    logic [NB*W-1:0] e_a, e_wd;
    int              e_win [NB];

    int nvec = 0;
    int nbad = 0;

    function automatic int bank_of(logic [W-1:0] a);
        return int'((a >> IDXW) & 32'd7);
    endfunction

    function automatic int idx_of(logic [W-1:0] a);
        return int'(a % RS);
    endfunction

    function automatic logic [W-1:0] mk(int b, int k);
        return W'((b << IDXW) | k);
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_ptr[b] = N - 1;
        m_rv  = '0;
        m_err = '0;
        m_rd  = '0;
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) begin
            rq_v[i] = 1'b0; rq_we[i] = 1'b0; rq_addr[i] = '0; rq_wd[i] = '0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            u_if.req[i]              = rq_v[i];
            u_if.req_we[i]           = rq_we[i];
            u_if.req_addr[i*W +: W]  = rq_addr[i];
            u_if.req_wdata[i*W +: W] = rq_wd[i];
        end
    endtask

    // Compute expected outputs from the arbitration rules and compare at the falling edge.
    task automatic eval();
        #4;
        if (reset) model_reset();
        e_gnt = '0; e_we = '0; e_a = '0; e_wd = '0;
        for (int b = 0; b < NB; b++) begin
            e_win[b] = -1;
            if (PRIO && rq_v[0] && bank_of(rq_addr[0]) == b) e_win[b] = 0;
            for (int k = 1; k <= N && e_win[b] < 0; k++) begin
                int i;
                i = (m_ptr[b] + k) % N;
                if (rq_v[i] && bank_of(rq_addr[i]) == b) e_win[b] = i;
            end
            if (e_win[b] >= 0) begin
                e_gnt[e_win[b]]  = 1'b1;
                e_we[b]          = rq_we[e_win[b]];
                e_a[b*W +: W]    = W'(idx_of(rq_addr[e_win[b]]));
                e_wd[b*W +: W]   = rq_wd[e_win[b]];
            end
        end
        for (int i = 0; i < N; i++)
            if (rq_v[i] && bank_of(rq_addr[i]) == 7) e_gnt[i] = 1'b1;
        if (reset) begin
            e_gnt = '0;
            e_we  = '0;
        end
        chk("gnt",    u_if.gnt,    e_gnt);
        chk("mem_we", u_if.mem_we, e_we);
        if (!reset) begin
            chk("mem_a",  u_if.mem_a,  e_a);
            chk("mem_wd", u_if.mem_wd, e_wd);
        end
        chk("rvalid", u_if.rvalid, m_rv);
        chk("err",    u_if.err,    m_err);
        chk("rdata",  u_if.rdata,  m_rd);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_rv = e_gnt; m_err = '0; m_rd = '0;
            for (int i = 0; i < N; i++) begin
                if (e_gnt[i]) begin
                    if (bank_of(rq_addr[i]) == 7) m_err[i] = 1'b1;
                    else if (!rq_we[i]) m_rd[i*W +: W] = gold[bank_of(rq_addr[i])][idx_of(rq_addr[i])];
                end
            end
            for (int b = 0; b < NB; b++) begin
                if (e_win[b] >= 0) begin
                    if (!(PRIO && e_win[b] == 0)) m_ptr[b] = e_win[b];
                    if (e_we[b]) gold[b][idx_of(rq_addr[e_win[b]])] = rq_wd[e_win[b]];
                end
            end
        end
        #1;
    endtask

    task automatic cyc();
        drive(); eval(); advance();
    endtask

    initial begin
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < RS; k++) gold[b][k] = pat(b, k);
        reset = 1'b0; init_mem = 1'b0;
        idle(); drive();
        #2 reset = 1'b1; init_mem = 1'b1;
        @(posedge clk); #1;
        drive(); eval();
        chk("rst_gnt", u_if.gnt, 4'h0);
        chk("rst_rvalid", u_if.rvalid, 4'h0);
        advance();
        reset = 1'b0; init_mem = 1'b0;
        cyc();

        // 1: single read of bank 2 idx 5
        rq_v[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = mk(2, 5);
        drive(); eval();
        chk("t1_gnt0", u_if.gnt[0], 1'b1);
        chk("t1_mem_a2", u_if.mem_a[2*W +: W], 32'd5);
        advance();
        idle(); drive(); eval();
        chk("t1_rvalid0", u_if.rvalid[0], 1'b1);
        chk("t1_rdata0", u_if.rdata[0 +: W], 32'h0000_00A5);
        advance();

        // 2: two writers contend for bank 3 idx 0
        for (int c = 0; c < 4; c++) begin
            rq_v[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = mk(3, 0); rq_wd[0] = 32'h0000_D000;
            rq_v[1] = 1'b1; rq_we[1] = 1'b1; rq_addr[1] = mk(3, 0); rq_wd[1] = 32'h0000_D111;
            drive(); eval();
            chk("t2_gnt", u_if.gnt[1:0], (PRIO || c % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_we3", u_if.mem_we[3], 1'b1);
            advance();
        end
        idle(); cyc();
        chk("t2_mem3_0", mem[3][0], PRIO ? 32'h0000_D000 : 32'h0000_D111);

        // 3: four reads to four different banks proceed together
        for (int i = 0; i < N; i++) begin
            rq_v[i] = 1'b1; rq_we[i] = 1'b0; rq_addr[i] = mk(i, 1);
        end
        drive(); eval();
        chk("t3_gnt", u_if.gnt, 4'hF);
        advance();
        idle(); drive(); eval();
        chk("t3_rvalid", u_if.rvalid, 4'hF);
        chk("t3_rdata0", u_if.rdata[0 +: W], 32'hC000_0001);
        chk("t3_rdata3", u_if.rdata[3*W +: W], 32'hC003_0001);
        advance();

        // 4: illegal bank alongside a normal read
        rq_v[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = mk(0, 2);
        rq_v[2] = 1'b1; rq_we[2] = 1'b1; rq_addr[2] = mk(7, 3); rq_wd[2] = 32'hDEAD_BEEF;
        drive(); eval();
        chk("t4_gnt", u_if.gnt, 4'b0101);
        chk("t4_mem_we", u_if.mem_we, 7'h00);
        advance();
        idle(); drive(); eval();
        chk("t4_rvalid", u_if.rvalid, 4'b0101);
        chk("t4_err", u_if.err, 4'b0100);
        chk("t4_rdata2", u_if.rdata[2*W +: W], 32'h0);
        chk("t4_rdata0", u_if.rdata[0 +: W], 32'hC000_0002);
        advance();

        // 5: write then read-after-write on bank 6 idx 9
        rq_v[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = mk(6, 9); rq_wd[0] = 32'h0000_1234;
        rq_v[1] = 1'b1; rq_we[1] = 1'b0; rq_addr[1] = mk(6, 9);
        drive(); eval();
        chk("t5_gnt_w", u_if.gnt[1:0], 2'b01);
        advance();
        rq_v[0] = 1'b0;
        drive(); eval();
        chk("t5_gnt_r", u_if.gnt[1:0], 2'b10);
        advance();
        idle(); drive(); eval();
        chk("t5_rdata1", u_if.rdata[W +: W], 32'h0000_1234);
        advance();

        // 6: reset with a response pending, then contention on bank 1
        rq_v[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = mk(1, 4);
        cyc();
        idle();
        reset = 1'b1;
        drive(); eval();
        chk("t6_rvalid", u_if.rvalid, 4'h0);
        advance();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rq_v[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = mk(1, 0);
            rq_v[1] = 1'b1; rq_we[1] = 1'b0; rq_addr[1] = mk(1, 0);
            drive(); eval();
            chk("t6_gnt", u_if.gnt[1:0], (PRIO || c % 2 == 0) ? 2'b01 : 2'b10);
            advance();
        end
        idle(); cyc();

        // Random traffic: held requests, withdrawals, illegal banks, occasional reset
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom % 300 == 0);
            for (int i = 0; i < N; i++) begin
                if (!rq_v[i]) begin
                    if ($urandom % 4 != 0) begin
                        int b;
                        b = ($urandom % 12 == 0) ? 7 : int'($urandom % 7);
                        rq_v[i]    = 1'b1;
                        rq_we[i]   = $urandom % 2;
                        rq_addr[i] = ($urandom & ~32'hFFF) | mk(b, int'($urandom % 8));
                        rq_wd[i]   = $urandom;
                    end
                end else if ($urandom % 40 == 0) begin
                    rq_v[i] = 1'b0;
                end
            end
            cyc();
            for (int i = 0; i < N; i++)
                if (e_gnt[i]) rq_v[i] = 1'b0;
        end
        reset = 1'b0;
        idle(); cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
